// File: rtl/fwd_sel_gen_pkg.sv
// rtl/fwd_sel_gen_pkg.sv - shared register-index width and EX operand mux select encodings
//
// Shared by the forwarding controller and the EX-stage operand mux instances.
//   FWD_REG_ADDR_W : default register-index width
//   SEL_*          : 4:1 operand mux select codes
package fwd_sel_gen_pkg;

    localparam int FWD_REG_ADDR_W = 5;

    localparam logic [1:0] SEL_RF    = 2'b00;  // register-file read data
    localparam logic [1:0] SEL_EXMEM = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] SEL_MEMWB = 2'b10;  // MEM/WB write-back data
    localparam logic [1:0] SEL_RET   = 2'b11;  // RET hold register (value written last cycle)

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-operand forwarding priority encoder
//
// Ports:
//   rs, used                 : ID operand index and whether the instruction reads it
//   ex_wr/ex_rd              : current EX entry (valid & reg_write) and its destination
//   mem_wr/mem_rd            : current MEM entry
//   wb_wr/wb_rd              : current WB entry
//   sel                      : select the operand will need during its own EX cycle
module fwd_match
    import fwd_sel_gen_pkg::*;
#(
    parameter int REG_ADDR_W  = FWD_REG_ADDR_W,
    parameter bit ZERO_REG_HW = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic                  ex_wr,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_wr,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    logic rs_zero;

    // x0 is hardwired: nothing ever forwards into it.
    assign rs_zero = ZERO_REG_HW && (rs == '0);

    // By the time this operand reaches EX, each producer has moved one stage
    // further on, so EX maps to EX/MEM, MEM to MEM/WB and WB to the RET hold.
    always_comb begin
        sel = SEL_RF;
        if (used && !rs_zero) begin
            if (ex_wr && (ex_rd == rs)) begin
                sel = SEL_EXMEM;
            end else if (mem_wr && (mem_rd == rs)) begin
                sel = SEL_MEMWB;
            end else if (wb_wr && (wb_rd == rs)) begin
                sel = SEL_RET;
            end
        end
    end

endmodule

// File: rtl/fwd_sel_gen.sv
// rtl/fwd_sel_gen.sv - EX operand forwarding select and load-use stall controller
//
// Ports:
//   clk, rst_n               : core clock, synchronous active-low reset
//   id_valid, id_rs1/rs2     : ID instruction presence and source registers
//   id_rs1_used/id_rs2_used  : which sources the instruction reads
//   id_rd, id_reg_write      : ID destination register and write enable
//   id_mem_read              : ID instruction is a load
//   flush                    : kill the ID->EX transfer
//   sel_a, sel_b             : registered EX operand mux selects
//   stall                    : combinational load-use stall (hold PC/IF-ID, bubble EX)
module fwd_sel_gen
    import fwd_sel_gen_pkg::*;
#(
    parameter int REG_ADDR_W  = FWD_REG_ADDR_W,
    parameter bit ZERO_REG_HW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic                  stall
);

    // Shadow pipeline. Only EX needs mem_read (load-use detection). The RET
    // occupant is never compared: the WB entry seen at select time is exactly
    // what sits in RET during the consumer's EX cycle.
    logic                  ex_valid, ex_reg_write, ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_valid, mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid, wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic       ex_rd_zero;
    logic       load_hit;
    logic       issue;
    logic [1:0] match_a, match_b;

    assign ex_rd_zero = ZERO_REG_HW && (ex_rd == '0);

    // A load in EX cannot supply its data to the next instruction's EX cycle.
    assign load_hit = ex_valid && ex_mem_read && ex_reg_write && !ex_rd_zero &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // flush wins: a killed instruction never needs to wait.
    assign stall = id_valid && !flush && load_hit;
    assign issue = id_valid && !flush && !stall;

    fwd_match #(
        .REG_ADDR_W  (REG_ADDR_W),
        .ZERO_REG_HW (ZERO_REG_HW)
    ) u_match_a (
        .rs     (id_rs1),
        .used   (id_rs1_used),
        .ex_wr  (ex_valid && ex_reg_write),
        .ex_rd  (ex_rd),
        .mem_wr (mem_valid && mem_reg_write),
        .mem_rd (mem_rd),
        .wb_wr  (wb_valid && wb_reg_write),
        .wb_rd  (wb_rd),
        .sel    (match_a)
    );

    fwd_match #(
        .REG_ADDR_W  (REG_ADDR_W),
        .ZERO_REG_HW (ZERO_REG_HW)
    ) u_match_b (
        .rs     (id_rs2),
        .used   (id_rs2_used),
        .ex_wr  (ex_valid && ex_reg_write),
        .ex_rd  (ex_rd),
        .mem_wr (mem_valid && mem_reg_write),
        .mem_rd (mem_rd),
        .wb_wr  (wb_valid && wb_reg_write),
        .wb_rd  (wb_rd),
        .sel    (match_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_rd         <= '0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            sel_a         <= SEL_RF;
            sel_b         <= SEL_RF;
        end else begin
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_rd         <= mem_rd;
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_rd        <= ex_rd;
            // Bubbles only need valid cleared; the other fields are don't-care.
            ex_valid      <= issue;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_rd         <= id_rd;
            sel_a         <= issue ? match_a : SEL_RF;
            sel_b         <= issue ? match_b : SEL_RF;
        end
    end

endmodule

// File: tb/tb_fwd_sel_gen.sv
// tb/tb_fwd_sel_gen.sv - self-checking bench for fwd_sel_gen
module tb_fwd_sel_gen;

    localparam int W    = 5;
    localparam bit ZERO = 1'b1;

    logic         clk;
    logic         rst_n;
    logic         id_valid;
    logic [W-1:0] id_rs1, id_rs2, id_rd;
    logic         id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic         flush;
    logic [1:0]   sel_a, sel_b;
    logic         stall;

    int vectors     = 0;
    int miscompares = 0;

    // Reference history: what entered EX over the last three edges.
    // Index 0 is the instruction now in EX, 1 in MEM, 2 in WB.
    logic         h_valid [3];
    logic         h_rw    [3];
    logic         h_mr    [3];
    logic [W-1:0] h_rd    [3];

    logic       exp_stall, obs_stall;
    logic [1:0] exp_a, exp_b, obs_a, obs_b;

    fwd_sel_gen #(
        .REG_ADDR_W  (W),
        .ZERO_REG_HW (ZERO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distance to the nearest older writer of r: 1 -> 01, 2 -> 10, 3 -> 11.
    function automatic logic [1:0] model_sel(logic [W-1:0] r, logic used);
        if (!used) return 2'b00;
        if (ZERO && r == 0) return 2'b00;
        for (int d = 0; d < 3; d++)
            if (h_valid[d] && h_rw[d] && h_rd[d] == r) return 2'(d + 1);
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        if (!id_valid || flush) return 1'b0;
        if (!(h_valid[0] && h_rw[0] && h_mr[0])) return 1'b0;
        if (ZERO && h_rd[0] == 0) return 1'b0;
        return (id_rs1_used && id_rs1 == h_rd[0]) || (id_rs2_used && id_rs2 == h_rd[0]);
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                         input logic u1, input logic u2, input logic [W-1:0] rd,
                         input logic rw, input logic mr, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock: records stall before the edge, selects after it,
    // and the reference model's expectation for each.
    task automatic step();
        logic iss;
        @(negedge clk);
        exp_stall = model_stall();
        obs_stall = stall;
        iss   = rst_n && id_valid && !flush && !exp_stall;
        exp_a = iss ? model_sel(id_rs1, id_rs1_used) : 2'b00;
        exp_b = iss ? model_sel(id_rs2, id_rs2_used) : 2'b00;
        @(posedge clk);
        for (int d = 2; d > 0; d--) begin
            h_valid[d] = h_valid[d-1]; h_rw[d] = h_rw[d-1];
            h_mr[d] = h_mr[d-1]; h_rd[d] = h_rd[d-1];
        end
        h_valid[0] = iss; h_rw[0] = id_reg_write; h_mr[0] = id_mem_read; h_rd[0] = id_rd;
        if (!rst_n) for (int d = 0; d < 3; d++) h_valid[d] = 1'b0;
        #1;
        obs_a = sel_a;
        obs_b = sel_b;
    endtask

    task automatic drain();
        nop(); step(); step(); step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nop();
        step();
        step();
        vectors++; if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", obs_stall); end
        vectors++; if (obs_a !== 2'b00) begin miscompares++; $display("FAIL reset_sel_a: got %b expected 00", obs_a); end
        vectors++; if (obs_b !== 2'b00) begin miscompares++; $display("FAIL reset_sel_b: got %b expected 00", obs_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0); step();   // add x5 <- x1,x2
        drive(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0); step();   // sub x6 <- x5,x3
        vectors++; if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall: got %b expected 0", obs_stall); end
        vectors++; if (obs_a !== 2'b01) begin miscompares++; $display("FAIL b2b_sel_a: got %b expected 01", obs_a); end
        vectors++; if (obs_b !== 2'b00) begin miscompares++; $display("FAIL b2b_sel_b: got %b expected 00", obs_b); end
        drain();
    endtask

    task automatic test_distance();
        logic [1:0] want;
        for (int gap = 1; gap <= 3; gap++) begin
            drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0); step();   // producer x7
            for (int k = 0; k < gap; k++) begin
                drive(1, 5'd1, 5'd2, 1, 1, 5'(20 + k), 1, 0, 0); step();
            end
            drive(1, 5'd3, 5'd7, 1, 1, 5'd9, 1, 0, 0); step();   // consumer rs2=x7
            want = (gap == 1) ? 2'b10 : (gap == 2) ? 2'b11 : 2'b00;
            vectors++; if (obs_b !== want) begin miscompares++; $display("FAIL dist%0d_sel_b: got %b expected %b", gap + 1, obs_b, want); end
            drain();
        end
    endtask

    task automatic test_load_use();
        drive(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0); step();   // lw x8
        drive(1, 5'd8, 5'd3, 1, 1, 5'd10, 1, 0, 0); step();  // add rs1=x8
        vectors++; if (obs_stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %b expected 1", obs_stall); end
        vectors++; if (obs_a !== 2'b00) begin miscompares++; $display("FAIL lu_bubble_sel_a: got %b expected 00", obs_a); end
        step();                                              // re-issued add
        vectors++; if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_once: got %b expected 0", obs_stall); end
        vectors++; if (obs_a !== 2'b10) begin miscompares++; $display("FAIL lu_reissue_sel_a: got %b expected 10", obs_a); end
        drain();
    endtask

    task automatic test_zero_unused();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 1, 0); step();   // load to x0
        drive(1, 5'd0, 5'd4, 1, 1, 5'd11, 1, 0, 0); step();  // consumer rs1=x0
        vectors++; if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL x0_stall: got %b expected 0", obs_stall); end
        vectors++; if (obs_a !== 2'b00) begin miscompares++; $display("FAIL x0_sel_a: got %b expected 00", obs_a); end
        drain();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd12, 1, 0, 0); step();  // producer x12
        drive(1, 5'd4, 5'd12, 1, 0, 5'd13, 1, 0, 0); step(); // rs2=x12 not read
        vectors++; if (obs_b !== 2'b00) begin miscompares++; $display("FAIL unused_sel_b: got %b expected 00", obs_b); end
        drain();
    endtask

    task automatic test_flush_reset();
        drive(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0); step();   // lw x8
        drive(1, 5'd8, 5'd3, 1, 1, 5'd10, 1, 0, 1); step();  // flushed consumer
        vectors++; if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b expected 0", obs_stall); end
        vectors++; if (obs_a !== 2'b00) begin miscompares++; $display("FAIL flush_sel_a: got %b expected 00", obs_a); end
        drain();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0, 0); step();  // producer x13
        drive(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0); step();   // lw x8
        drive(1, 5'd8, 5'd13, 1, 1, 5'd10, 1, 0, 0);
        rst_n = 1'b0; step();                                // reset mid-stall
        vectors++; if (obs_stall !== 1'b1) begin miscompares++; $display("FAIL rst_pre_stall: got %b expected 1", obs_stall); end
        vectors++; if (obs_a !== 2'b00) begin miscompares++; $display("FAIL rst_sel_a: got %b expected 00", obs_a); end
        rst_n = 1'b1; step();
        vectors++; if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL rst_post_stall: got %b expected 0", obs_stall); end
        vectors++; if (obs_a !== 2'b00) begin miscompares++; $display("FAIL rst_stale_a: got %b expected 00", obs_a); end
        vectors++; if (obs_b !== 2'b00) begin miscompares++; $display("FAIL rst_stale_b: got %b expected 00", obs_b); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
            step();
            vectors++; if (obs_stall !== exp_stall) begin miscompares++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, obs_stall, exp_stall); end
            vectors++; if (obs_a !== exp_a) begin miscompares++; $display("FAIL rand_sel_a[%0d]: got %b expected %b", i, obs_a, exp_a); end
            vectors++; if (obs_b !== exp_b) begin miscompares++; $display("FAIL rand_sel_b[%0d]: got %b expected %b", i, obs_b, exp_b); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            h_valid[d] = 1'b0; h_rw[d] = 1'b0; h_mr[d] = 1'b0; h_rd[d] = '0;
        end
        rst_n = 1'b0;
        nop();
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_zero_unused();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fwd_sel_gen.md
Name: fwd_sel_gen

Overview:
- Forwarding/hazard controller that produces the 2-bit selects for the EX-stage operand 4:1 muxes (rs1 path and rs2 path) of the 5-stage RISC-V core.
- Maintains a shadow pipeline of destination-register info (EX, MEM, WB, RET stages).
- Registers the selects so they are stable throughout the EX cycle.
- Raises a load-use stall and inserts a bubble when forwarding cannot cover the hazard.

Parameters:
- REG_ADDR_W, 5, register-index width.
- ZERO_REG_HW, 1, when 1 register index 0 never matches: no forwarding, no stall.

Ports:
- clk  input  1  core clock, all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_ADDR_W  source register 1 of ID instruction
- id_rs2  input  REG_ADDR_W  source register 2 of ID instruction
- id_rs1_used  input  1  instruction reads rs1
- id_rs2_used  input  1  instruction reads rs2
- id_rd  input  REG_ADDR_W  destination register of ID instruction
- id_reg_write  input  1  instruction writes rd
- id_mem_read  input  1  instruction is a load
- flush  input  1  kill the ID→EX transfer (branch taken or jump)
- sel_a  output  2  EX operand-A mux select
- sel_b  output  2  EX operand-B mux select
- stall  output  1  hold PC and IF/ID, bubble into EX (combinational)

Behaviour:
- Mux input map (fixed):
  - 00 = register-file read data
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB write-back data
  - 11 = RET hold register (value written one cycle earlier; covers the register file's lack of internal write-before-read bypass)
- Shadow entries: each of EX, MEM, WB, RET holds {valid, rd, reg_write, mem_read}.
  - Every cycle: RET←WB, WB←MEM, MEM←EX.
  - EX←ID fields, or a bubble (valid=0) when stall, flush or !id_valid.
- Entry "writes r" when valid & reg_write & rd==r & !(ZERO_REG_HW & r==0).
- Select computation for the ID operand r, evaluated combinationally and registered at the edge, applying to the instruction's EX cycle:
  - Priority is nearest stage first:
    - current EX writes r → 01
    - else current MEM writes r → 10
    - else current WB writes r → 11
    - else 00
  - An unused operand always gets 00.
- stall = id_valid & !flush & EX.valid & EX.mem_read & EX.reg_write & EX.rd≠0 (when ZERO_REG_HW) & ((id_rs1_used & rs1==EX.rd) | (id_rs2_used & rs2==EX.rd)).
  - Lasts exactly one cycle per load-use pair: after the bubble the load sits in MEM, so the re-evaluated select becomes 10.
- On stall, flush or !id_valid: EX←bubble and sel_a/sel_b←00 at the edge.
- flush has priority over stall; stall is forced 0 while flush=1.
- Reset (rst_n=0 at an edge): all shadow valid bits 0, sel_a=sel_b=00, stall=0 (combinational from cleared state). Reset asserted mid-stall drops stall in the next cycle.
- Latency: one cycle from ID sample to sel valid; stall has zero latency.
- No arithmetic; comparisons are equality on REG_ADDR_W bits only.

Decomposition:
- Shared package/header: REG_ADDR_W and the select encodings SEL_RF=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10, SEL_RET=2'b11. These are reused by the datapath mux instances.
- One natural sub-module, fwd_match: the per-operand priority encoder (operand index + 3 stage entries → 2-bit select). Instantiate it twice.

Test Plan:
- Back-to-back ALU: add x5 ← x1,x2, then sub x6 ← x5,x3 → second instruction sees sel_a=01, sel_b=00, stall=0.
- Distance 2 and 3: producer x7, one independent instruction, consumer rs2=x7 → sel_b=10. With two independent instructions in between → sel_b=11. With three in between → 00.
- Load-use: lw x8, then add rs1=x8 → stall=1 for exactly 1 cycle and EX bubble. The re-issued add gets sel_a=10.
- x0 and unused operands: producer rd=x0 with consumer rs1=x0 → sel_a=00, no stall. Consumer with rs2_used=0 and a matching rs2 → sel_b=00.
- Flush and reset: flush during a load-use match → stall=0, next sel=00. rst_n low for 1 cycle mid-pipeline → all sel 00, stale producers no longer forwarded.
